// File: rtl/rv32_mem_pkg.sv
`default_nettype none
//==============================================================================
// rv32_mem_pkg : shared FSM encodings and requester IDs for mem_arb_rv32.
// Rev 1.0
//==============================================================================
package rv32_mem_pkg;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_IBUSY = 2'd1;
  localparam logic [1:0] c_ST_DBUSY = 2'd2;
  localparam logic [1:0] c_ST_IDROP = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = c_ST_IDLE,
    IBUSY = c_ST_IBUSY,
    DBUSY = c_ST_DBUSY,
    IDROP = c_ST_IDROP
  } state_t;

  // Requester IDs double as round-robin pointer values.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_rv32_if.sv
`default_nettype none
//==============================================================================
// mem_arb_rv32_if : fetch, data and memory-bus signals of mem_arb_rv32.
// master = arbiter view, slave = core/memory view.  Rev 1.0
//==============================================================================
interface mem_arb_rv32_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          iIReq;
  logic [AW-1:0] iIAddr;
  logic          iFlush;
  logic [DW-1:0] oIRData;
  logic          oIValid;
  logic          oIStall;

  logic          iDReq;
  logic          iDWe;
  logic [AW-1:0] iDAddr;
  logic [DW-1:0] iDWData;
  logic [3:0]    iDBe;
  logic [DW-1:0] oDRData;
  logic          oDValid;
  logic          oDStall;

  logic          oBusReq;
  logic          oBusWe;
  logic [AW-1:0] oBusAddr;
  logic [DW-1:0] oBusWData;
  logic [3:0]    oBusBe;
  logic          iBusAck;
  logic [DW-1:0] iBusRData;

  modport master (
    input  iIReq, iIAddr, iFlush, iDReq, iDWe, iDAddr, iDWData, iDBe,
           iBusAck, iBusRData,
    output oIRData, oIValid, oIStall, oDRData, oDValid, oDStall,
           oBusReq, oBusWe, oBusAddr, oBusWData, oBusBe
  );

  modport slave (
    output iIReq, iIAddr, iFlush, iDReq, iDWe, iDAddr, iDWData, iDBe,
           iBusAck, iBusRData,
    input  oIRData, oIValid, oIStall, oDRData, oDValid, oDStall,
           oBusReq, oBusWe, oBusAddr, oBusWData, oBusBe
  );
endinterface
`default_nettype wire

// File: rtl/mem_arb_pick_rv32.sv
`default_nettype none
//==============================================================================
// mem_arb_pick_rv32 : grant selection between eligible fetch and data sides.
// MEM_ARB_RR_EN adds a 1-bit round-robin pointer; otherwise data wins.  Rev 1.0
//==============================================================================
module mem_arb_pick_rv32
  import rv32_mem_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic iCLK,
  input  logic iRST,
`endif
  input  logic iEligI,
  input  logic iEligD,
  output logic oGrantI,
  output logic oGrantD
);

`ifdef MEM_ARB_RR_EN
  logic rPtr;

  // Pointer names the side that wins the next conflict.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rPtr <= REQ_D;
    end else if (oGrantD) begin
      rPtr <= REQ_I;
    end else if (oGrantI) begin
      rPtr <= REQ_D;
    end
  end

  always_comb begin
    oGrantD = iEligD & (~iEligI | (rPtr == REQ_D));
    oGrantI = iEligI & ~oGrantD;
  end
`else
  always_comb begin
    oGrantD = iEligD;
    oGrantI = iEligI & ~iEligD;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_arb_rv32.sv
`default_nettype none
//==============================================================================
// mem_arb_rv32 : one-transaction-at-a-time fetch/MEM arbiter for a req/ack bus.
// Optional MEM_ARB_RR_EN: round-robin instead of data-first conflicts.  Rev 1.0
//==============================================================================
module mem_arb_rv32
  import rv32_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic           iCLK,
  input  logic           iRST,
  mem_arb_rv32_if.master arb
);

  localparam logic [AW-1:0] c_ALIGN = {{(AW-2){1'b1}}, 2'b00};

  state_t        rState;
  state_t        wNext;
  logic          wEligI;
  logic          wEligD;
  logic          wGrantI;
  logic          wGrantD;
  logic          rIValid;
  logic          rDValid;
  logic [DW-1:0] rIRData;
  logic [DW-1:0] rDRData;
  logic          rBusWe;
  logic [AW-1:0] rBusAddr;
  logic [DW-1:0] rBusWData;
  logic [3:0]    rBusBe;

  // A side whose valid is up this cycle is finishing, so it is not re-granted.
  assign wEligI = (rState == IDLE) & arb.iIReq & ~rIValid & ~arb.iFlush;
  assign wEligD = (rState == IDLE) & arb.iDReq & ~rDValid;

  mem_arb_pick_rv32 uPick (
`ifdef MEM_ARB_RR_EN
    .iCLK    (iCLK),
    .iRST    (iRST),
`endif
    .iEligI  (wEligI),
    .iEligD  (wEligD),
    .oGrantI (wGrantI),
    .oGrantD (wGrantD)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) rState <= IDLE;
    else      rState <= wNext;
  end

  always_comb begin
    wNext = rState;
    case (rState)
      IDLE:    if (wGrantD) wNext = DBUSY;
               else if (wGrantI) wNext = IBUSY;
      IBUSY:   if (arb.iBusAck) wNext = IDLE;
               else if (arb.iFlush) wNext = IDROP;
      DBUSY:   if (arb.iBusAck) wNext = IDLE;
      IDROP:   if (arb.iBusAck) wNext = IDLE;
      default: wNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rIValid   <= 1'b0;
      rDValid   <= 1'b0;
      rIRData   <= '0;
      rDRData   <= '0;
      rBusWe    <= 1'b0;
      rBusAddr  <= '0;
      rBusWData <= '0;
      rBusBe    <= 4'h0;
    end else begin
      // A flush coinciding with the ack throws the fetched word away.
      rIValid <= (rState == IBUSY) & arb.iBusAck & ~arb.iFlush;
      rDValid <= (rState == DBUSY) & arb.iBusAck;
      if ((rState == IBUSY) && arb.iBusAck && !arb.iFlush) rIRData <= arb.iBusRData;
      if ((rState == DBUSY) && arb.iBusAck) rDRData <= arb.iBusRData;
      if (wGrantD) begin
        rBusWe    <= arb.iDWe;
        rBusAddr  <= arb.iDAddr & c_ALIGN;
        rBusWData <= arb.iDWData;
        rBusBe    <= arb.iDBe;
      end else if (wGrantI) begin
        rBusWe    <= 1'b0;
        rBusAddr  <= arb.iIAddr & c_ALIGN;
        rBusWData <= '0;
        rBusBe    <= 4'hF;
      end
    end
  end

  assign arb.oBusReq   = (rState != IDLE);
  assign arb.oBusWe    = rBusWe;
  assign arb.oBusAddr  = rBusAddr;
  assign arb.oBusWData = rBusWData;
  assign arb.oBusBe    = rBusBe;
  assign arb.oIRData   = rIRData;
  assign arb.oIValid   = rIValid;
  assign arb.oIStall   = arb.iIReq & ~rIValid;
  assign arb.oDRData   = rDRData;
  assign arb.oDValid   = rDValid;
  assign arb.oDStall   = arb.iDReq & ~rDValid;

endmodule
`default_nettype wire

// File: doc/mem_arb_rv32.md
# mem_arb_rv32

Single-port memory arbiter for the RV32I core. It shares one synchronous request/acknowledge memory bus between the instruction-fetch stage and the load/store (MEM) stage. It sequences one bus transaction at a time and returns read data with a registered valid pulse. It generates the per-side stall that holds the PC and the MEM stage while the bus is busy, and it discards a fetch cancelled by a taken branch.

## Interface
Parameters:
- AW, 32, bus address width; word-aligned, bits [1:0] forced to 0 on the bus.
- DW, 32, data width.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  reset, synchronous, active-high.
- iIReq  in  1  fetch request; held with iIAddr until oIValid.
- iIAddr  in  AW  fetch address (PC).
- iFlush  in  1  taken branch; cancels the current or pending fetch.
- oIRData  out  DW  fetched instruction.
- oIValid  out  1  one-cycle pulse; oIRData valid.
- oIStall  out  1  iIReq & ~oIValid; drives the fetch stall.
- iDReq  in  1  data request; held until oDValid.
- iDWe  in  1  1 = store.
- iDAddr  in  AW  data address.
- iDWData  in  DW  store data.
- iDBe  in  4  store byte enables.
- oDRData  out  DW  load data.
- oDValid  out  1  one-cycle pulse; load data / store done.
- oDStall  out  1  iDReq & ~oDValid.
- oBusReq  out  1  bus request.
- oBusWe, oBusAddr, oBusWData, oBusBe  out  1/AW/DW/4  bus command, stable while oBusReq=1.
- iBusAck  in  1  slave completes the transfer this cycle.
- iBusRData  in  DW  read data, valid with iBusAck.

## Operation
- FSM states: IDLE, IBUSY, DBUSY, IDROP.
- IDLE: picks among eligible requesters. A side is eligible if its request is high and its valid is low this cycle, so a held request is never re-granted on its completion cycle.
  - Data only -> DBUSY. Instruction only, with iFlush=0 -> IBUSY. Both -> arbitration policy (see Configuration).
  - iFlush=1 blocks the instruction grant in that cycle.
- On grant, the bus command registers latch the winner's address, we, wdata and be. The instruction side has we=0 and be=4'hF.
- IBUSY/DBUSY: oBusReq=1. The command is held constant until iBusAck.
  - On ack: read data goes into oIRData/oDRData, the matching valid is set for one cycle, and the FSM returns to IDLE.
- IBUSY with iFlush=1 and no ack in the same cycle -> IDROP. The bus command is held, since an issued request is never withdrawn.
- IBUSY with iFlush=1 and iBusAck in the same cycle: the data is dropped, oIValid stays 0, and the FSM goes to IDLE.
- IDROP: on iBusAck -> IDLE with no oIValid.
- Stores complete through oDValid; oDRData is don't-care for stores.
- Reset values: state IDLE, oBusReq 0, oIValid 0, oDValid 0, oIRData 0, oDRData 0, bus command 0, RR pointer = data.
- Reset mid-transaction: IDLE with oBusReq=0 on the next cycle. The bus slave must tolerate the abandoned request.

## Timing
- Zero-wait slave: request seen at edge N, oBusReq from N+1, ack in N+1, valid in N+2. That is 2 cycles per access.
- With W wait states, latency is 2+W cycles.
- Back-to-back: a new grant is possible in the IDLE cycle that carries the previous valid, giving a throughput of 1 access per 2 cycles.
- Stalls are combinational from request and valid. No other comb path runs from bus inputs to outputs.
- oIValid is never asserted in the cycle after iFlush=1 while the fetch was outstanding.

## Configuration
- MEM_ARB_RR_EN undefined: fixed priority; data always wins a conflict, since the MEM stage is the older instruction.
- MEM_ARB_RR_EN defined: round-robin on conflict.
  - A 1-bit pointer gives priority to the side not served last, and is updated on each grant.
  - A single-requester grant also updates it.

## Structure
- Package rv32_mem_pkg holds the FSM state localparams (2-bit encoding) and the requester IDs REQ_I/REQ_D.
- Sub-module mem_arb_pick_rv32: combinational selection from eligible-I, eligible-D and the RR pointer, with the pointer flop inside it under MEM_ARB_RR_EN.

## Test plan
- Fetch only, iIAddr=0x100, zero-wait ack, iBusRData=0x00500093:
  - Expected: oBusAddr=0x100 at N+1, oIValid with oIRData=0x00500093 at N+2, and oIStall high in N and N+1.
- Simultaneous iIReq (0x104) and load (iDAddr=0x2000), fixed priority:
  - Expected: the data access is served first, then the fetch, with no third grant of either.
- Same conflict with MEM_ARB_RR_EN, repeated 4 times:
  - Expected: grants alternate I/D after the first D.
- Store iDWe=1, iDBe=4'b0011, iDWData=0xDEADBEEF, 3 wait states:
  - Expected: the bus command is held stable for 4 cycles and oDValid is set 5 cycles after the request.
- Fetch in IBUSY, iFlush pulsed, ack 2 cycles later:
  - Expected: state goes to IDROP, oIValid stays 0, the new fetch at the branch target is granted afterwards, and iFlush+ack in the same cycle also suppresses oIValid.
- iRST asserted during DBUSY:
  - Expected: oBusReq=0 and all valids 0 on the next cycle, and the FSM restarts cleanly from IDLE.
